rgbi_pwm_dac: RTL and testbench
===============================

Name: rgbi_pwm_dac

Overview:
- Output-side counterpart of the per-channel comparator ADC: converts digital colour codes back to analog drive levels.
- Accepts red, green, blue and intensity codes through a valid/ready load handshake.
- Scales each colour by intensity using a sequential shift-add multiply.
- Drives three RC-filtered PWM outputs; new values take effect only on a PWM period boundary, so outputs are glitch-free.

Parameters:
- N, 8: colour code width and PWM counter width.
- M, 6: intensity code width.
- PRESCALE, 18: clk cycles per PWM counter tick. Legal range 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- red_in  input  N  red colour code
- green_in  input  N  green colour code
- blue_in  input  N  blue colour code
- intensity_in  input  M  intensity code
- load  input  1  request valid; inputs captured when load && ready at posedge clk
- ready  output  1  block can accept a new load
- pwm  output  3  [2]=red, [1]=green, [0]=blue; registered PWM outputs
- period_start  output  1  one-clk pulse when the PWM counter wraps to 0
- busy  output  1  high while a load is being scaled or waiting to be applied

Behaviour:
- Reset (async, active-high):
  - State = IDLE; prescaler = 0; PWM count = 0.
  - Active duty registers = 0; staging registers = 0.
  - pwm = 3'b000, period_start = 0, busy = 0, ready = 0.
  - ready rises on the first posedge clk after reset deasserts.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick = 1 on the cycle it equals PRESCALE-1.
  - The PWM count (N bits) increments on tick and wraps from 2^N-1 to 0.
  - period_start is registered: high for exactly one clk, the cycle after the count becomes 0.
- PWM output: pwm[i] is registered each clk as (pwm_count < active[i]).
  - Duty 0 gives a constant low output.
  - Duty 2^N-1 gives high for 255 of 256 counts.
- Scaling arithmetic:
  - Formula: scaled = (colour × (intensity+1)) >> M.
  - Multiplier is M+1 bits; product is N+M+1 bits; result is truncated to N bits.
  - intensity = 2^M-1 returns the colour exactly (255×64>>6 = 255). intensity = 0 gives colour>>6.
  - All three channels are computed in parallel.
  - One multiplier bit per clk, LSB first, so the multiply takes M+1 = 7 cycles.
- FSM:
  - IDLE: ready = 1, busy = 0. On load && ready: capture the four inputs, clear the step counter, go to SCALE.
  - SCALE: ready = 0, busy = 1. Performs one shift-add step per clk. After step M (the 7th cycle), write the three results to staging and go to WAIT.
  - WAIT: ready = 0, busy = 1. On the cycle where tick = 1 and pwm_count = 2^N-1, copy staging to active and go to IDLE. The new duty therefore applies from count 0 of the next period.
- Boundary rules:
  - load while ready = 0 is ignored. Inputs need not be held after capture.
  - Entering WAIT on the same cycle as a wrap tick does not apply; the apply waits for the next period end.
  - A period shorter than the scaling time is permitted; WAIT simply spans extra periods.
  - After apply, ready is high on the next clk. Worst-case load-to-apply latency is 7 + (2^N × PRESCALE) clk.
  - Reset mid-SCALE or mid-WAIT discards captured and staged values; active duties return to 0.

Decomposition:
- Shared package rgbi_pkg:
  - FSM state encodings IDLE=2'b00, SCALE=2'b01, WAIT=2'b10 (default maps to IDLE).
  - Defaults for N, M, PRESCALE.
  - Channel index constants RED=2, GREEN=1, BLUE=0, matching the ADC bank ordering.
- Sub-module shift_add_scaler (one instance per colour):
  - Inputs: clk, reset, start, colour[N], mult[M+1].
  - Outputs: result[N], done.
  - The top-level FSM sequences the three instances in lockstep.

Test Plan:
- Reset and defaults: assert reset mid-run, release it → pwm = 000, period_start = 0, ready = 0 during reset; ready = 1 one clk after release; pwm stays 000 for a full period.
- Full-scale load: PRESCALE=1, load R=255 G=128 B=0 I=63 → busy for 7 clk plus the wait to period end. Next period has red high 255 of 256 counts, green high 128 counts, blue always low.
- Intensity scaling: R=200 G=100 B=64 I=31 → active = 100, 50, 32. Then I=0 → 3, 1, 1.
- Glitch-free update: load while pwm_count = 10 → pwm unchanged until after count 255 wraps. The new duty starts at count 0, aligned with the period_start pulse.
- Handshake: hold load high for 3 consecutive clk, changing values each clk → only the first set is captured. ready stays low until apply, then rises one clk later.
- Reset mid-operation: assert reset during SCALE step 3, then during WAIT → no apply ever occurs; active duties = 0, FSM is in IDLE after release.

Source files
------------

// File: rtl/rgbi_pkg.sv
// Shared definitions for the RGBI PWM DAC: FSM encoding, parameter defaults
// and channel indices (same ordering as the comparator ADC bank).
package rgbi_pkg;

    localparam int unsigned N_DEF        = 8;
    localparam int unsigned M_DEF        = 6;
    localparam int unsigned PRESCALE_DEF = 18;

    localparam int unsigned RED   = 2;
    localparam int unsigned GREEN = 1;
    localparam int unsigned BLUE  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SCALE = 2'b01,
        WAIT  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_add_scaler.sv
// Sequential LSB-first shift-add multiply: result = (colour * mult) >> M,
// one multiplier bit per clk, done asserted during the final (M-th) step.
module shift_add_scaler
    import rgbi_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned M = M_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] colour,
    input  logic [M:0]   mult,
    output logic [N-1:0] result,
    output logic         done
);

    localparam int unsigned PW = N + M + 1;
    localparam int unsigned SW = $clog2(M + 2);

    logic [PW-1:0] acc;
    logic [PW-1:0] addend;
    logic [PW-1:0] sum;
    logic [M:0]    mult_sh;
    logic [SW-1:0] step;
    logic          running;

    // The last partial product is folded in combinationally so the result
    // is available in the same cycle as done.
    always_comb begin
        sum = acc + (mult_sh[0] ? addend : '0);
    end

    assign done   = running && (step == SW'(M));
    assign result = sum[M +: N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            addend  <= '0;
            mult_sh <= '0;
            step    <= '0;
            running <= 1'b0;
        end else if (start) begin
            acc     <= '0;
            addend  <= PW'(colour);
            mult_sh <= mult;
            step    <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc     <= sum;
            addend  <= addend << 1;
            mult_sh <= mult_sh >> 1;
            step    <= step + SW'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rgbi_pwm_dac.sv
// RGBI to three-channel PWM DAC: intensity-scaled colour duties, applied only
// at a PWM period boundary so the filtered outputs never glitch.
module rgbi_pwm_dac
    import rgbi_pkg::*;
#(
    parameter int unsigned N        = N_DEF,
    parameter int unsigned M        = M_DEF,
    parameter int unsigned PRESCALE = PRESCALE_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] red_in,
    input  logic [N-1:0] green_in,
    input  logic [N-1:0] blue_in,
    input  logic [M-1:0] intensity_in,
    input  logic         load,
    output logic         ready,
    output logic [2:0]   pwm,
    output logic         period_start,
    output logic         busy
);

    state_t       state;
    state_t       next_state;
    logic [7:0]   presc;
    logic         tick;
    logic [N-1:0] pwm_count;
    logic         wrap;
    logic         wrap_q;
    logic         capture;
    logic         apply;
    logic [M:0]   mult;
    logic [N-1:0] colour_in [3];
    logic [N-1:0] scaled    [3];
    logic [N-1:0] staging   [3];
    logic [N-1:0] active    [3];
    logic [2:0]   done;

    assign tick    = (presc == 8'(PRESCALE - 1));
    assign wrap    = tick && (pwm_count == '1);
    assign capture = load && ready;
    assign apply   = (state == WAIT) && wrap;
    assign mult    = (M+1)'(intensity_in) + (M+1)'(1);
    assign busy    = (state != IDLE);

    always_comb begin
        colour_in[RED]   = red_in;
        colour_in[GREEN] = green_in;
        colour_in[BLUE]  = blue_in;
    end

    for (genvar c = 0; c < 3; c++) begin : g_ch
        shift_add_scaler #(
            .N(N),
            .M(M)
        ) u_scaler (
            .clk   (clk),
            .reset (reset),
            .start (capture),
            .colour(colour_in[c]),
            .mult  (mult),
            .result(scaled[c]),
            .done  (done[c])
        );
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (capture) next_state = SCALE;
            SCALE:   if (&done)   next_state = WAIT;
            WAIT:    if (apply)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ready <= 1'b0;
        end else begin
            state <= next_state;
            ready <= (next_state == IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc        <= '0;
            pwm_count    <= '0;
            wrap_q       <= 1'b0;
            period_start <= 1'b0;
        end else begin
            presc        <= tick ? '0 : presc + 8'd1;
            pwm_count    <= tick ? pwm_count + N'(1) : pwm_count;
            wrap_q       <= wrap;
            // Delayed one extra clk so the pulse lines up with the pwm sample
            // of count 0 (pwm itself lags the counter by one register).
            period_start <= wrap_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 3; i++) begin
                staging[i] <= '0;
                active[i]  <= '0;
            end
            pwm <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (state == SCALE && (&done)) begin
                    staging[i] <= scaled[i];
                end
                if (apply) begin
                    active[i] <= staging[i];
                end
                pwm[i] <= (pwm_count < active[i]);
            end
        end
    end

endmodule

// File: tb/tb_rgbi_pwm_dac.sv
// Scoreboard bench for rgbi_pwm_dac: stimulus queues expected duties, a monitor
// measures high counts over each PWM period and compares against them.
module tb_rgbi_pwm_dac;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] red_in, green_in, blue_in;
    logic [5:0] intensity_in;
    logic       load;
    logic       ready, period_start, busy;
    logic [2:0] pwm;

    logic       rst3;
    logic       ready3, ps3, busy3;
    logic [2:0] pwm3;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_q [$];

    always #5 clk = ~clk;

    rgbi_pwm_dac #(.N(8), .M(6), .PRESCALE(1)) dut (
        .clk(clk), .reset(reset), .red_in(red_in), .green_in(green_in),
        .blue_in(blue_in), .intensity_in(intensity_in), .load(load),
        .ready(ready), .pwm(pwm), .period_start(period_start), .busy(busy)
    );

    rgbi_pwm_dac #(.N(8), .M(6), .PRESCALE(3)) dut3 (
        .clk(clk), .reset(rst3), .red_in(8'd0), .green_in(8'd0),
        .blue_in(8'd0), .intensity_in(6'd0), .load(1'b0),
        .ready(ready3), .pwm(pwm3), .period_start(ps3), .busy(busy3)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one window per PWM period, starting at the period_start pulse.
    logic [23:0] exp_act;
    int          hi [3];
    int          win_len;
    bit          in_win, apply_pend, busy_prev;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_act    = '0;
            in_win     = 0;
            apply_pend = 0;
            busy_prev  = 0;
        end else begin
            if (busy_prev && !busy) apply_pend = 1;
            busy_prev = busy;
            if (period_start) begin
                if (in_win) begin
                    check("window_len", win_len, 256);
                    check("duty_blue",  hi[0], int'(exp_act[7:0]));
                    check("duty_green", hi[1], int'(exp_act[15:8]));
                    check("duty_red",   hi[2], int'(exp_act[23:16]));
                end
                if (apply_pend) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_apply", 1, 0);
                    end else begin
                        exp_act = exp_q.pop_front();
                    end
                    apply_pend = 0;
                end
                in_win  = 1;
                win_len = 0;
                for (int c = 0; c < 3; c++) hi[c] = 0;
            end
            if (in_win) begin
                win_len++;
                for (int c = 0; c < 3; c++) hi[c] += int'(pwm[c]);
            end
        end
    end

    // Period length of the PRESCALE=3 instance: 256 counts x 3 clk.
    int  n3 = 0;
    int  done3 = 0;
    bit  seen3 = 0;
    always @(negedge clk) begin
        if (!rst3) begin
            n3++;
            if (ps3) begin
                if (seen3 && done3 < 2) begin
                    check("p3_period", n3, 768);
                    check("p3_pwm_idle", int'(pwm3), 0);
                    done3++;
                end
                seen3 = 1;
                n3 = 0;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int n = 0;
        while (!ready && n < 1000) begin
            step();
            n++;
        end
        if (!ready) check("ready_timeout", 0, 1);
    endtask

    task automatic wait_period;
        int n = 0;
        step();
        while (!period_start && n < 1000) begin
            step();
            n++;
        end
        if (!period_start) check("period_timeout", 0, 1);
    endtask

    task automatic do_load(input logic [7:0] r, g, b, input logic [5:0] i,
                           input logic [7:0] er, eg, eb);
        wait_ready();
        red_in = r; green_in = g; blue_in = b; intensity_in = i;
        load = 1'b1;
        exp_q.push_back({er, eg, eb});
        step();
        load = 1'b0;
        red_in = '0; green_in = '0; blue_in = '0; intensity_in = '0;
        check("busy_after_load", int'(busy), 1);
        check("ready_after_load", int'(ready), 0);
    endtask

    initial begin
        reset = 1'b1; rst3 = 1'b1; load = 1'b0;
        red_in = '0; green_in = '0; blue_in = '0; intensity_in = '0;
        repeat (3) step();
        check("rst_ready", int'(ready), 0);
        check("rst_pwm", int'(pwm), 0);
        check("rst_period_start", int'(period_start), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0; rst3 = 1'b0;
        step();
        check("ready_after_release", int'(ready), 1);
        repeat (2) wait_period();

        // Full scale, then intensity scaling at half and zero intensity.
        do_load(8'd255, 8'd128, 8'd0, 6'd63, 8'd255, 8'd128, 8'd0);
        wait_ready(); repeat (2) wait_period();
        do_load(8'd200, 8'd100, 8'd64, 6'd31, 8'd100, 8'd50, 8'd32);
        wait_ready(); repeat (2) wait_period();
        do_load(8'd200, 8'd100, 8'd64, 6'd0, 8'd3, 8'd1, 8'd1);
        wait_ready(); repeat (2) wait_period();

        // Load mid-period: previous duty must hold until the wrap.
        wait_period();
        repeat (9) step();
        do_load(8'd17, 8'd240, 8'd85, 6'd47, 8'd12, 8'd180, 8'd63);
        wait_ready(); repeat (2) wait_period();

        // Load held for three clk with changing data: only the first is taken.
        wait_ready();
        red_in = 8'd60; green_in = 8'd30; blue_in = 8'd255; intensity_in = 6'd15;
        load = 1'b1;
        exp_q.push_back({8'd15, 8'd7, 8'd63});
        step();
        check("hs_ready_1", int'(ready), 0);
        red_in = 8'd99; green_in = 8'd99; blue_in = 8'd99; intensity_in = 6'd63;
        step();
        check("hs_ready_2", int'(ready), 0);
        red_in = 8'd1; green_in = 8'd2; blue_in = 8'd3; intensity_in = 6'd5;
        step();
        load = 1'b0;
        wait_ready();
        check("hs_busy_at_ready", int'(busy), 0);
        repeat (2) wait_period();

        // Reset during SCALE.
        do_load(8'd10, 8'd20, 8'd30, 6'd63, 8'd10, 8'd20, 8'd30);
        repeat (2) step();
        reset = 1'b1;
        #1;
        check("rs_scale_ready", int'(ready), 0);
        check("rs_scale_busy", int'(busy), 0);
        repeat (2) step();
        check("rs_scale_pwm", int'(pwm), 0);
        reset = 1'b0;
        step();
        check("rs_scale_idle", int'(ready), 1);
        repeat (2) wait_period();

        // Reset during WAIT.
        wait_period();
        do_load(8'd250, 8'd250, 8'd250, 6'd63, 8'd250, 8'd250, 8'd250);
        repeat (20) step();
        check("rs_wait_busy", int'(busy), 1);
        reset = 1'b1;
        repeat (2) step();
        check("rs_wait_pwm", int'(pwm), 0);
        reset = 1'b0;
        step();
        check("rs_wait_idle", int'(ready), 1);
        check("rs_wait_notbusy", int'(busy), 0);
        repeat (3) wait_period();

        check("queue_empty", exp_q.size(), 0);
        check("p3_periods_seen", done3, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
